// File: rtl/axi4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_pkg
//  Description : Shared definitions for the AXI4 burst master: response
//                codes, master state encoding and the watchdog limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi4_pkg;

  // AXI response codes used by the master
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  // Cycles a channel may wait for its handshake before the watchdog fires
  localparam int c_TIMEOUT_CYCLES = 256;

  // Master transaction states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } mst_state_t;

endpackage
`default_nettype wire

// File: rtl/axi4_master_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_master_wdog
//  Description : Handshake watchdog. Counts consecutive cycles spent waiting
//                on an AXI channel and flags the cycle in which the wait
//                reaches TIMEOUT cycles without a handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_master_wdog #(
  parameter int TIMEOUT = 256
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic active,
  input  logic handshake,
  output logic timeout
);

  localparam int                c_CW    = $clog2(TIMEOUT);
  localparam logic [c_CW-1:0]   c_LIMIT = c_CW'(TIMEOUT - 1);

  logic [c_CW-1:0] r_cnt;

  // Wait-cycle counter: restarts on every handshake and whenever no channel is waiting
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_cnt <= '0;
    end else if (!active || handshake) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The last permitted waiting cycle ends without a handshake
  assign timeout = active && !handshake && (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/axi4_burst_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_burst_master
//  Description : Single-outstanding AXI4 burst master. Accepts one command
//                at a time, runs the AW/W/B or AR/R sequence, and reports
//                completion with a one-cycle done pulse plus err.
//                Optional watchdog: define AXI4_MASTER_TIMEOUT_EN to abort a
//                transaction whose channel waits 256 cycles for a handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_burst_master
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // write address
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  // write data
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  output logic                  WLAST,
  input  logic                  WREADY,
  // write response
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  // read address
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  // read data
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  input  logic                  RLAST,
  output logic                  RREADY,
  // command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  // write-data source
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  // read-data sink
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  // status
  output logic                  done,
  output logic                  err
);

  // Largest legal AxSIZE: one beat may not exceed the data bus width
  localparam logic [2:0] c_MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  mst_state_t            r_state;
  mst_state_t            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_nxt;
  logic                  r_err;
  logic                  w_err_nxt;
  logic                  w_cmd_take;
  logic                  w_timeout;

`ifdef AXI4_MASTER_TIMEOUT_EN
  logic w_active;
  logic w_hs;

  // A channel is waiting in any bus state; a handshake on that channel restarts the wait
  assign w_active = (r_state == S_AW) || (r_state == S_W) || (r_state == S_B) ||
                    (r_state == S_AR) || (r_state == S_R);
  assign w_hs     = ((r_state == S_AW) && AWREADY) ||
                    ((r_state == S_W)  && wr_valid && WREADY) ||
                    ((r_state == S_B)  && BVALID) ||
                    ((r_state == S_AR) && ARREADY) ||
                    ((r_state == S_R)  && RVALID);

  axi4_master_wdog #(
    .TIMEOUT   (c_TIMEOUT_CYCLES)
  ) u_wdog (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .active    (w_active),
    .handshake (w_hs),
    .timeout   (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // State register; asynchronous reset aborts any burst in flight
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command fields, beat counter and sticky error
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_addr <= '0;
      r_len  <= '0;
      r_size <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_cmd_take) begin
        r_addr <= cmd_addr;
        r_len  <= cmd_len;
        r_size <= cmd_size;
      end
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end

  // Next-state decode and all channel outputs
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_cmd_take  = 1'b0;
    cmd_ready   = 1'b0;
    AWADDR      = r_addr;
    AWLEN       = r_len;
    AWSIZE      = r_size;
    AWVALID     = 1'b0;
    ARADDR      = r_addr;
    ARLEN       = r_len;
    ARSIZE      = r_size;
    ARVALID     = 1'b0;
    WDATA       = '0;
    WVALID      = 1'b0;
    WLAST       = 1'b0;
    wr_ready    = 1'b0;
    BREADY      = 1'b0;
    RREADY      = 1'b0;
    rd_data     = '0;
    rd_valid    = 1'b0;
    rd_last     = 1'b0;
    done        = 1'b0;
    err         = 1'b0;

    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_cmd_take = 1'b1;
          w_cnt_nxt  = 8'd0;
          w_err_nxt  = 1'b0;
          if (cmd_size > c_MAX_SIZE) begin
            // Oversized beats never reach the bus
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = cmd_write ? S_AW : S_AR;
          end
        end
      end

      S_AW: begin
        AWVALID = 1'b1;
        if (AWREADY) w_state_nxt = S_W;
      end

      S_W: begin
        WVALID   = wr_valid;
        wr_ready = WREADY;
        WDATA    = wr_data;
        WLAST    = (r_cnt == r_len);
        if (wr_valid && WREADY) begin
          if (r_cnt == r_len) begin
            w_state_nxt = S_B;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end

      S_B: begin
        BREADY = 1'b1;
        if (BVALID) begin
          w_err_nxt   = (BRESP != c_RESP_OKAY);
          w_state_nxt = S_DONE;
        end
      end

      S_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) w_state_nxt = S_R;
      end

      S_R: begin
        RREADY   = 1'b1;
        rd_valid = RVALID;
        rd_data  = RDATA;
        rd_last  = RLAST;
        if (RVALID) begin
          w_cnt_nxt = r_cnt + 8'd1;
          if (RRESP != c_RESP_OKAY) w_err_nxt = 1'b1;
          if (RLAST) begin
            // Short burst: RLAST before the expected beat count
            if (r_cnt != r_len) w_err_nxt = 1'b1;
            w_state_nxt = S_DONE;
            w_cnt_nxt   = 8'd0;
          end else if (r_cnt == r_len) begin
            // Long burst: expected last beat arrived without RLAST
            w_err_nxt = 1'b1;
          end
        end
      end

      S_DONE: begin
        done        = 1'b1;
        err         = r_err;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Watchdog abort overrides whatever the stalled channel would do
    if (w_timeout) begin
      w_state_nxt = S_DONE;
      w_err_nxt   = 1'b1;
      w_cnt_nxt   = 8'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_burst_master
//  Description : Directed self-checking bench for axi4_burst_master with a
//                small memory-backed AXI slave that answers SLVERR on bursts
//                crossing a 4 KB boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_burst_master;
  import axi4_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic        WVALID, WLAST, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic [15:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic        ARVALID, ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID, RLAST, RREADY;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_last;
  logic        done, err;

  axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .done(done), .err(err)
  );

  always #5 ACLK = ~ACLK;

  // slave model state
  logic [31:0] mem [0:1023];
  logic [31:0] wbuf [0:255];
  logic [15:0] s_awaddr, s_araddr;
  logic [7:0]  s_awlen, s_arlen;
  logic [1:0]  b_resp;
  int          aw_delay, ar_delay, aw_wait, ar_wait, s_wn, r_idx, cb_last;
  bit          aw_block, b_pending, r_pending;
  // write-data feed
  logic [31:0] feed [0:15];
  int          feed_n, feed_i;
  // monitors
  logic [31:0] rd_cap [0:15];
  int          w_beats, wlast_cnt, wlast_beat, done_cnt, rd_n, rd_last_idx, awv_seen, arv_seen;
  int          total, bad;

  // Sample handshakes at the active edge (pre-update values) and update the slave
  always @(posedge ACLK) begin
    if (ARESETn) begin
      if (AWVALID) awv_seen++;
      if (ARVALID) arv_seen++;
      if (AWVALID && AWREADY) begin
        s_awaddr = AWADDR; s_awlen = AWLEN; s_wn = 0; aw_wait = 0;
      end
      if (wr_valid && wr_ready) feed_i++;
      if (WVALID && WREADY) begin
        wbuf[s_wn & 255] = WDATA;
        s_wn++; w_beats++;
        if (WLAST) begin
          wlast_cnt++;
          if (wlast_beat < 0) wlast_beat = w_beats - 1;
          cb_last = int'(s_awaddr) + s_wn * 4 - 1;
          if ((int'(s_awaddr) >> 12) != (cb_last >> 12)) begin
            b_resp = c_RESP_SLVERR;
          end else begin
            b_resp = c_RESP_OKAY;
            for (int i = 0; i < s_wn; i++) mem[((int'(s_awaddr) >> 2) + i) & 1023] = wbuf[i & 255];
          end
          b_pending = 1'b1;
        end
      end
      if (BVALID && BREADY) b_pending = 1'b0;
      if (ARVALID && ARREADY) begin
        s_araddr = ARADDR; s_arlen = ARLEN; r_idx = 0; r_pending = 1'b1; ar_wait = 0;
      end
      if (RVALID && RREADY) begin
        if (RLAST) r_pending = 1'b0;
        r_idx++;
      end
      if (rd_valid) begin
        rd_cap[rd_n & 15] = rd_data;
        if (rd_last) rd_last_idx = rd_n;
        rd_n++;
      end
      if (done) done_cnt++;
    end
  end

  // Drive slave responses and the write-data feed on the falling edge
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      AWREADY = 0; ARREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
      RVALID = 0; RLAST = 0; RDATA = 0; RRESP = 0; wr_valid = 0; wr_data = 0;
      b_pending = 0; r_pending = 0; aw_wait = 0; ar_wait = 0; s_wn = 0;
    end else begin
      if (AWVALID) aw_wait++;
      AWREADY = AWVALID && !aw_block && (aw_wait > aw_delay);
      if (ARVALID) ar_wait++;
      ARREADY = ARVALID && (ar_wait > ar_delay);
      WREADY  = 1'b1;
      BVALID  = b_pending;
      BRESP   = b_resp;
      RRESP   = c_RESP_OKAY;
      if (r_pending) begin
        RVALID = 1'b1;
        RDATA  = mem[((int'(s_araddr) >> 2) + r_idx) & 1023];
        RLAST  = (r_idx == int'(s_arlen));
      end else begin
        RVALID = 1'b0; RLAST = 1'b0; RDATA = '0;
      end
      wr_valid = (feed_i < feed_n);
      wr_data  = (feed_i < feed_n) ? feed[feed_i & 15] : 32'h0;
    end
  end

  task automatic clr_mon();
    w_beats = 0; wlast_cnt = 0; wlast_beat = -1; rd_n = 0; rd_last_idx = -1;
    feed_i = 0; feed_n = 0;
  endtask

  task automatic issue(input bit wr, input logic [15:0] a, input logic [7:0] l, input logic [2:0] s);
    @(negedge ACLK);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL cmd_ready_before_issue got=%b exp=1", cmd_ready); end
    cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_valid = 1'b1;
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit found, output logic e);
    cycles = 0; found = 0; e = 1'bx;
    while (!found && cycles < budget) begin
      if (done === 1'b1) begin found = 1; e = err; end
      else begin @(negedge ACLK); cycles++; end
    end
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if ({AWVALID, ARVALID, WVALID, BREADY, RREADY} !== 5'b0) begin bad++; $display("FAIL rst_valids got=%b exp=00000", {AWVALID, ARVALID, WVALID, BREADY, RREADY}); end
    total++; if ({done, err} !== 2'b00) begin bad++; $display("FAIL rst_status got=%b exp=00", {done, err}); end
    total++; if ({AWADDR, AWLEN, AWSIZE} !== 27'h0) begin bad++; $display("FAIL rst_aw_fields got=%h exp=0", {AWADDR, AWLEN, AWSIZE}); end
    ARESETn = 1'b1;
  endtask

  task automatic test_write();
    int cyc; bit f; logic e;
    clr_mon();
    for (int i = 0; i < 4; i++) feed[i] = 32'hA0 + i;
    feed_n = 4;
    issue(1'b1, 16'h0010, 8'd3, 3'd2);
    wait_done(60, cyc, f, e);
    total++; if (!f) begin bad++; $display("FAIL wr_done_seen got=0 exp=1"); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL wr_err got=%b exp=0", e); end
    total++; if (w_beats != 4) begin bad++; $display("FAIL wr_beats got=%0d exp=4", w_beats); end
    total++; if (wlast_cnt != 1 || wlast_beat != 3) begin bad++; $display("FAIL wr_wlast got=cnt%0d/beat%0d exp=cnt1/beat3", wlast_cnt, wlast_beat); end
    total++; if (s_awaddr !== 16'h0010 || s_awlen !== 8'd3) begin bad++; $display("FAIL wr_aw got=%h/%0d exp=0010/3", s_awaddr, s_awlen); end
    @(negedge ACLK);
    total++; if (done !== 1'b0 || done_cnt != 1) begin bad++; $display("FAIL wr_done_pulse got=done%b/cnt%0d exp=done0/cnt1", done, done_cnt); end
    for (int i = 0; i < 4; i++) begin
      total++; if (mem[4 + i] !== 32'hA0 + i) begin bad++; $display("FAIL wr_mem%0d got=%h exp=%h", 4 + i, mem[4 + i], 32'hA0 + i); end
    end
  endtask

  task automatic test_read();
    int cyc; bit f; logic e;
    clr_mon();
    issue(1'b0, 16'h0010, 8'd3, 3'd2);
    wait_done(60, cyc, f, e);
    total++; if (!f) begin bad++; $display("FAIL rd_done_seen got=0 exp=1"); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL rd_err got=%b exp=0", e); end
    total++; if (rd_n != 4 || rd_last_idx != 3) begin bad++; $display("FAIL rd_beats got=n%0d/last%0d exp=n4/last3", rd_n, rd_last_idx); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_cap[i] !== 32'hA0 + i) begin bad++; $display("FAIL rd_data%0d got=%h exp=%h", i, rd_cap[i], 32'hA0 + i); end
    end
    @(negedge ACLK);
  endtask

  task automatic test_4k_cross();
    int cyc; bit f; logic e;
    clr_mon();
    for (int i = 0; i < 4; i++) feed[i] = 32'hB0 + i;
    feed_n = 4;
    issue(1'b1, 16'h0FF8, 8'd3, 3'd2);
    wait_done(60, cyc, f, e);
    total++; if (!f) begin bad++; $display("FAIL x4k_done_seen got=0 exp=1"); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL x4k_err got=%b exp=1", e); end
    total++; if (w_beats != 4) begin bad++; $display("FAIL x4k_beats got=%0d exp=4", w_beats); end
    total++; if (mem[1022] !== 32'h0) begin bad++; $display("FAIL x4k_mem got=%h exp=0", mem[1022]); end
    @(negedge ACLK);
  endtask

  task automatic test_bad_size();
    int aw0, ar0;
    aw0 = awv_seen; ar0 = arv_seen;
    issue(1'b1, 16'h0020, 8'd0, 3'd3);
    total++; if ({done, err} !== 2'b11) begin bad++; $display("FAIL bsz_wr_done_err got=%b exp=11", {done, err}); end
    @(negedge ACLK);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL bsz_wr_pulse got=%b exp=0", done); end
    issue(1'b0, 16'h0020, 8'd1, 3'd7);
    total++; if ({done, err} !== 2'b11) begin bad++; $display("FAIL bsz_rd_done_err got=%b exp=11", {done, err}); end
    total++; if (awv_seen != aw0 || arv_seen != ar0) begin bad++; $display("FAIL bsz_no_traffic got=aw%0d/ar%0d exp=aw%0d/ar%0d", awv_seen, arv_seen, aw0, ar0); end
    @(negedge ACLK);
  endtask

  task automatic test_slow_ready();
    int cyc; bit f; logic e; int aw0;
    clr_mon();
    aw_delay = 5; ar_delay = 4;
    feed[0] = 32'h55; feed_n = 1;
    aw0 = awv_seen;
    issue(1'b1, 16'h0040, 8'd0, 3'd2);
    wait_done(60, cyc, f, e);
    total++; if (!f || e !== 1'b0) begin bad++; $display("FAIL slow_wr_done got=found%0d/err%b exp=found1/err0", f, e); end
    total++; if (awv_seen - aw0 != 6) begin bad++; $display("FAIL slow_awvalid_cycles got=%0d exp=6", awv_seen - aw0); end
    total++; if (w_beats != 1 || wlast_beat != 0) begin bad++; $display("FAIL slow_len0_wlast got=beats%0d/at%0d exp=beats1/at0", w_beats, wlast_beat); end
    issue(1'b0, 16'h0040, 8'd0, 3'd2);
    wait_done(60, cyc, f, e);
    total++; if (!f || e !== 1'b0) begin bad++; $display("FAIL slow_rd_done got=found%0d/err%b exp=found1/err0", f, e); end
    total++; if (rd_n != 1 || rd_last_idx != 0 || rd_cap[0] !== 32'h55) begin bad++; $display("FAIL slow_rd_data got=n%0d/last%0d/%h exp=n1/last0/55", rd_n, rd_last_idx, rd_cap[0]); end
    aw_delay = 0; ar_delay = 0;
    @(negedge ACLK);
  endtask

  task automatic test_reset_mid_burst();
    int cyc; bit f; logic e; int dc; int n;
    clr_mon();
    for (int i = 0; i < 8; i++) feed[i] = 32'hC0 + i;
    feed_n = 8;
    issue(1'b1, 16'h0080, 8'd7, 3'd2);
    n = 0;
    while (w_beats < 1 && n < 20) begin @(negedge ACLK); n++; end
    total++; if (w_beats != 1 || WVALID !== 1'b1) begin bad++; $display("FAIL mid_beat2_pending got=beats%0d/wvalid%b exp=beats1/wvalid1", w_beats, WVALID); end
    dc = done_cnt;
    ARESETn = 1'b0;
    #1;
    total++; if ({WVALID, AWVALID, BREADY, cmd_ready} !== 4'b0001) begin bad++; $display("FAIL mid_rst_drop got=%b exp=0001", {WVALID, AWVALID, BREADY, cmd_ready}); end
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (3) @(negedge ACLK);
    total++; if (done_cnt != dc) begin bad++; $display("FAIL mid_no_done got=%0d exp=%0d", done_cnt, dc); end
    clr_mon();
    feed[0] = 32'hD0; feed[1] = 32'hD1; feed_n = 2;
    issue(1'b1, 16'h0090, 8'd1, 3'd2);
    wait_done(60, cyc, f, e);
    total++; if (!f || e !== 1'b0) begin bad++; $display("FAIL mid_next_done got=found%0d/err%b exp=found1/err0", f, e); end
    total++; if (w_beats != 2 || mem[36] !== 32'hD0 || mem[37] !== 32'hD1) begin bad++; $display("FAIL mid_next_data got=beats%0d/%h/%h exp=beats2/d0/d1", w_beats, mem[36], mem[37]); end
    @(negedge ACLK);
  endtask

`ifdef AXI4_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int cyc; bit f; logic e;
    clr_mon();
    aw_block = 1'b1;
    issue(1'b1, 16'h0100, 8'd0, 3'd2);
    wait_done(400, cyc, f, e);
    total++; if (!f || cyc != 256) begin bad++; $display("FAIL tmo_cycles got=found%0d/cyc%0d exp=found1/cyc256", f, cyc); end
    total++; if (e !== 1'b1 || AWVALID !== 1'b0) begin bad++; $display("FAIL tmo_err got=err%b/awvalid%b exp=err1/awvalid0", e, AWVALID); end
    aw_block = 1'b0;
    @(negedge ACLK);
  endtask
`endif

  initial begin
    total = 0; bad = 0; done_cnt = 0; awv_seen = 0; arv_seen = 0;
    aw_delay = 0; ar_delay = 0; aw_block = 0; b_resp = 0; s_wn = 0; r_idx = 0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0;
    AWREADY = 0; ARREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    RVALID = 0; RLAST = 0; RDATA = 0; RRESP = 0; wr_valid = 0; wr_data = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    clr_mon();
    test_reset();
    test_write();
    test_read();
    test_4k_cross();
    test_bad_size();
    test_slow_ready();
    test_reset_mid_burst();
`ifdef AXI4_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/axi4_burst_master.md
AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning RDATA/WDATA width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning AWADDR/ARADDR/cmd_addr width in bits.
REQ-003 SHALL have port ACLK, input, 1 bit: clock; all logic on rising edge.
REQ-004 SHALL have port ARESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have the AW group: AWADDR out ADDR_WIDTH; AWLEN out 8; AWSIZE out 3; AWVALID out 1; AWREADY in 1.
REQ-006 SHALL have the W group: WDATA out DATA_WIDTH; WVALID out 1; WLAST out 1; WREADY in 1.
REQ-007 SHALL have the B group: BRESP in 2; BVALID in 1; BREADY out 1.
REQ-008 SHALL have the AR group: ARADDR out ADDR_WIDTH; ARLEN out 8; ARSIZE out 3; ARVALID out 1; ARREADY in 1.
REQ-009 SHALL have the R group: RDATA in DATA_WIDTH; RRESP in 2; RVALID in 1; RLAST in 1; RREADY out 1.
REQ-010 SHALL have the command group: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1 = write); cmd_addr in ADDR_WIDTH; cmd_len in 8 (beats-1); cmd_size in 3.
REQ-011 SHALL have the write-data group: wr_data in DATA_WIDTH; wr_valid in 1; wr_ready out 1.
REQ-012 SHALL have the read-data group: rd_data out DATA_WIDTH; rd_valid out 1; rd_last out 1.
REQ-013 SHALL have the status group: done out 1 (one-cycle pulse); err out 1 (valid only with done).

Function
REQ-014 SHALL run one FSM, states IDLE, AW, W, B, AR, R, DONE; one transaction outstanding at a time.
REQ-015 SHALL drive cmd_ready = (state==IDLE); on cmd_valid&&cmd_ready it latches addr/len/size and goes to AW (cmd_write=1) or AR (cmd_write=0).
REQ-016 SHALL reject cmd_size > log2(DATA_WIDTH/8): no AXI traffic, go directly to DONE with err=1.
REQ-017 SHALL hold AWVALID/ARVALID high and AxADDR/AxLEN/AxSIZE stable from entry to AW/AR until the AxREADY handshake; next state W or R.
REQ-018 SHALL in W drive WVALID = wr_valid, wr_ready = WREADY, WDATA = wr_data (combinational; all 0 outside W).
REQ-019 SHALL count W handshakes 0..len with an 8-bit counter; WLAST = (count==len); cmd_len=0 asserts WLAST on the first beat; the last handshake moves to B.
REQ-020 SHALL in B hold BREADY=1, capture BRESP on BVALID, and go to DONE; err = (BRESP != 2'b00).
REQ-021 SHALL in R hold RREADY=1 and forward rd_valid = RVALID, rd_data = RDATA, rd_last = RLAST (0 outside R).
REQ-022 SHALL leave R on the RLAST handshake; err is sticky if any beat has RRESP != 2'b00 or the beat count != len+1.
REQ-023 SHALL not split 4 KB-crossing bursts; the slave's SLVERR is reported through err.
REQ-024 SHALL pulse done for exactly one cycle in DONE, then return to IDLE; a new command is accepted the following cycle.
REQ-025 SHALL tolerate AxREADY arriving any number of cycles after AxVALID, including a gap after the previous burst.

Reset
REQ-026 SHALL, while ARESETn=0, force state IDLE, all AXI VALID/READY outputs 0, done=0, err=0, counters 0, AxADDR/AxLEN/AxSIZE 0, cmd_ready=1.
REQ-027 SHALL, on reset mid-burst, drop all valids immediately and emit no done for the aborted transaction.

Configuration
REQ-028 SHALL, with AXI4_MASTER_TIMEOUT_EN defined, abort to DONE with err=1 and valids low when any of AW, W, B, AR or R waits 256 cycles without a handshake.
REQ-029 SHALL, without AXI4_MASTER_TIMEOUT_EN, wait indefinitely; the watchdog logic SHALL be absent.

Structure
REQ-030 SHALL take from package axi4_pkg: response codes OKAY=2'b00 and SLVERR=2'b10, the master state enum, and the timeout constant 256.
REQ-031 SHALL place the watchdog in sub-module axi4_master_wdog, instantiated only under the macro.

Verification
REQ-032 SHALL cover: write addr 0x0010, len 3, size 2, data 0xA0..0xA3 -> 4 W beats, WLAST on beat 4, done with err=0, memory words 4..7 = 0xA0..0xA3.
REQ-033 SHALL cover: read addr 0x0010, len 3 after REQ-032 -> rd_data 0xA0..0xA3, rd_last on beat 4, err=0.
REQ-034 SHALL cover: write addr 0x0FF8, len 3, size 2 (crosses 4 KB) -> BRESP=SLVERR, done with err=1.
REQ-035 SHALL cover: cmd_size=3 with DATA_WIDTH 32 -> no AWVALID/ARVALID, done with err=1 one cycle later.
REQ-036 SHALL cover: ARESETn low during W beat 2 of len 7 -> WVALID=0 the same cycle, no done; next command completes normally.
REQ-037 SHALL cover (macro defined): AWREADY held 0 -> done with err=1 after 256 cycles.
